// File: rtl/chess_kbd_pkg.sv
// rtl/chess_kbd_pkg.sv - PS/2 scan-code constants and FSM states for chess move entry
package chess_kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Element i holds the set-2 make code for file/rank i (a..h, 1..8).
    localparam logic [7:0][7:0] FILE_CODES = {8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C};
    localparam logic [7:0][7:0] RANK_CODES = {8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16};

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        BREAK_SKIP,
        EXT_SKIP,
        PRESENT
    } state_t;

endpackage

// File: rtl/move_entry_controller_if.sv
// rtl/move_entry_controller_if.sv - keyboard-in / move-out signal bundle
interface move_entry_controller_if;
    logic       code_valid;
    logic [7:0] code;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] from_file;
    logic [2:0] from_rank;
    logic [2:0] to_file;
    logic [2:0] to_rank;
    logic [2:0] key_count;
    logic       entry_error;

    modport master (
        output code_valid, code, move_ready,
        input  move_valid, from_file, from_rank, to_file, to_rank, key_count, entry_error
    );

    modport slave (
        input  code_valid, code, move_ready,
        output move_valid, from_file, from_rank, to_file, to_rank, key_count, entry_error
    );
endinterface

// File: rtl/scan_decode.sv
// rtl/scan_decode.sv - combinational scan-code to board coordinate decode
module scan_decode
    import chess_kbd_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_file,
    output logic       is_rank,
    output logic [2:0] idx
);

    always_comb begin
        is_file = 1'b0;
        is_rank = 1'b0;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (code == FILE_CODES[i]) begin
                is_file = 1'b1;
                idx     = 3'(i);
            end
            if (code == RANK_CODES[i]) begin
                is_rank = 1'b1;
                idx     = 3'(i);
            end
        end
    end

endmodule

// File: rtl/move_entry_controller.sv
// rtl/move_entry_controller.sv - collects file/rank keystrokes into a move and hands it off
module move_entry_controller
    import chess_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    move_entry_controller_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    state_t          r_ret_state;
    logic [3:0][2:0] r_slot;
    logic [2:0]      r_key_count;
    logic [7:0]      r_last_make;
    logic [TW-1:0]   r_timer;
    logic            r_move_valid;
    logic            r_entry_error;

    logic       w_is_file;
    logic       w_is_rank;
    logic [2:0] w_idx;
    logic [1:0] w_kc_lo;
    logic       w_class_ok;
    logic       w_timing;
    logic       w_timeout;

    scan_decode u_decode (
        .code    (bus.code),
        .is_file (w_is_file),
        .is_rank (w_is_rank),
        .idx     (w_idx)
    );

    assign w_kc_lo    = r_key_count[1:0];
    // Even slots take files, odd slots take ranks.
    assign w_class_ok = (r_key_count < 3'd4) && (r_key_count[0] ? w_is_rank : w_is_file);
    assign w_timing   = (r_key_count != 3'd0) && (r_state != PRESENT);
    assign w_timeout  = w_timing && !bus.code_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ret_state   <= IDLE;
            r_slot        <= '0;
            r_key_count   <= 3'd0;
            r_last_make   <= 8'h00;
            r_timer       <= '0;
            r_move_valid  <= 1'b0;
            r_entry_error <= 1'b0;
        end else begin
            r_entry_error <= 1'b0;
            if (!w_timing || bus.code_valid || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_timeout) begin
                r_slot        <= '0;
                r_key_count   <= 3'd0;
                r_last_make   <= 8'h00;
                r_entry_error <= 1'b1;
                r_state       <= IDLE;
            end else begin
                case (r_state)
                    IDLE, COLLECT: begin
                        if (bus.code_valid) begin
                            if (bus.code == SC_BREAK) begin
                                r_ret_state <= r_state;
                                r_state     <= BREAK_SKIP;
                            end else if (bus.code == SC_EXT) begin
                                r_ret_state <= r_state;
                                r_state     <= EXT_SKIP;
                            end else if (bus.code != r_last_make) begin
                                r_last_make <= bus.code;
                                if (bus.code == SC_ESC) begin
                                    r_slot      <= '0;
                                    r_key_count <= 3'd0;
                                    r_state     <= IDLE;
                                end else if (bus.code == SC_BKSP) begin
                                    if (r_key_count != 3'd0) begin
                                        r_slot[w_kc_lo - 2'd1] <= 3'd0;
                                        r_key_count            <= r_key_count - 3'd1;
                                        r_state                <= (r_key_count == 3'd1) ? IDLE : COLLECT;
                                    end
                                end else if (bus.code == SC_ENTER) begin
                                    if (r_key_count == 3'd4) begin
                                        r_state      <= PRESENT;
                                        r_move_valid <= 1'b1;
                                    end else begin
                                        r_entry_error <= 1'b1;
                                    end
                                end else if (w_class_ok) begin
                                    r_slot[w_kc_lo] <= w_idx;
                                    r_key_count     <= r_key_count + 3'd1;
                                    r_state         <= COLLECT;
                                end else if (w_is_file || w_is_rank || (r_key_count != 3'd4)) begin
                                    r_entry_error <= 1'b1;
                                end
                            end
                        end
                    end
                    BREAK_SKIP: begin
                        if (bus.code_valid) begin
                            r_last_make <= 8'h00;
                            r_state     <= r_ret_state;
                        end
                    end
                    EXT_SKIP: begin
                        if (bus.code_valid) begin
                            r_state <= (bus.code == SC_BREAK) ? BREAK_SKIP : r_ret_state;
                        end
                    end
                    PRESENT: begin
                        if (bus.move_ready) begin
                            r_slot       <= '0;
                            r_key_count  <= 3'd0;
                            r_move_valid <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.move_valid  = r_move_valid;
    assign bus.from_file   = r_slot[0];
    assign bus.from_rank   = r_slot[1];
    assign bus.to_file     = r_slot[2];
    assign bus.to_rank     = r_slot[3];
    assign bus.key_count   = r_key_count;
    assign bus.entry_error = r_entry_error;

endmodule
